// File: rtl/protocore_pkg.sv
// ---------------------------------------------------------------------------
// protocore_pkg
// Shared definitions for the ProtoCore control path: the sequencer state
// encoding, the opcode values the sequencer itself cares about and the
// instruction word width.
// ---------------------------------------------------------------------------
package protocore_pkg;

  localparam int INSTR_W = 24;

  // Only the opcodes that change the sequencer's own flow live here; every
  // other opcode is the decoder's business.
  localparam logic [3:0] OP_LOAD  = 4'hA;
  localparam logic [3:0] OP_STORE = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WB,
    HALTED
  } state_t;

  // True for the opcodes that need a data-memory access before writeback.
  function automatic logic isMemOp(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/core_sequencer_pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program counter register for the ProtoCore sequencer. Holds the PC,
// selects between the sequential successor and the decoder-supplied jump
// target, and reloads RESET_PC on reset.
//
// Ports
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_load       update the PC this cycle (writeback cycle only)
//   i_overwrite  take i_target instead of pc+1
//   i_target     8-bit jump target from the ALU
//   o_pc         current program counter
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_overwrite,
  input  logic [7:0]      i_target,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_next;

  // The ALU is always 8 bits wide, so the jump target is zero-extended for
  // wider PCs and keeps only its low bits for narrower ones.
  generate
    if (PC_W > 8) begin : g_extend
      assign w_target = {{(PC_W-8){1'b0}}, i_target};
    end else if (PC_W == 8) begin : g_same
      assign w_target = i_target;
    end else begin : g_truncate
      assign w_target = i_target[PC_W-1:0];
    end
  endgenerate

  // The sequential successor wraps naturally at the top of the address space.
  assign w_next = i_overwrite ? w_target : (r_pc + PC_W'(1));

  // PC register: only moves when the sequencer says this is the writeback
  // cycle, so decoder jump requests in any other cycle are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= w_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/core_sequencer.sv
// ---------------------------------------------------------------------------
// core_sequencer
// Multi-cycle control FSM for the ProtoCore datapath. Fetches 24-bit
// instruction words over a req/ack port into the instruction register,
// presents the IR to the decoder, runs an optional data-memory access for
// load/store, then retires the instruction in a single writeback cycle where
// the register-file write and the PC update take effect.
//
// Ports
//   clk, rst_n         core clock / asynchronous active-low reset
//   imem_req           instruction fetch request (registered)
//   imem_addr          fetch address, always equal to pc
//   imem_ack           fetch complete, imem_rdata valid in the same cycle
//   imem_rdata         fetched instruction word
//   instruction        IR contents towards the decoder
//   dec_write_en       decoder register-write request
//   dec_halt           decoder HALT indication
//   dec_pc_overwrite   decoder jump / branch-taken
//   alu_result         ALU output, used as the jump target
//   rf_write_en        register-file write strobe, writeback cycle only
//   dmem_req           data memory request (load/store)
//   dmem_we            1 = store, 0 = load; valid while dmem_req
//   dmem_ack           data access complete
//   pc                 current program counter
//   halted             core has executed HALT
//   retired_count      saturating count of retired instructions
// ---------------------------------------------------------------------------
module core_sequencer
  import protocore_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  input  logic               dec_write_en,
  input  logic               dec_halt,
  input  logic               dec_pc_overwrite,
  input  logic [7:0]         alu_result,
  output logic               rf_write_en,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_count
);

  state_t             r_state;
  logic [INSTR_W-1:0] r_ir;
  logic [CNT_W-1:0]   r_retired;
  logic               r_imemReq;
  logic               r_dmemReq;
  logic               r_dmemWe;
  logic               r_wbStrobe;
  logic               r_halted;

  logic [3:0]         w_opcode;
  logic               w_pcLoad;
  logic [PC_W-1:0]    w_pc;

  assign w_opcode = r_ir[INSTR_W-1:INSTR_W-4];
  assign w_pcLoad = (r_state == WB);

  pc_unit #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pcUnit (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_pcLoad),
    .i_overwrite (dec_pc_overwrite),
    .i_target    (alu_result),
    .o_pc        (w_pc)
  );

  // Main sequencer. State, IR, retired counter and all request/status
  // outputs are updated together here so every output is a flop.
  // imem_req is low in the first cycle after reset release and only an ack
  // seen while the request flop is high is accepted, which is what makes a
  // stale ack straddling reset harmless. r_wbStrobe marks the writeback
  // cycle; it is set on the edge that enters WB and cleared on the edge that
  // leaves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_ir       <= '0;
      r_retired  <= '0;
      r_imemReq  <= 1'b0;
      r_dmemReq  <= 1'b0;
      r_dmemWe   <= 1'b0;
      r_wbStrobe <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_wbStrobe <= 1'b0;
      case (r_state)
        FETCH: begin
          if (r_imemReq && imem_ack) begin
            r_ir      <= imem_rdata;
            r_imemReq <= 1'b0;
            r_state   <= DECODE;
          end else begin
            r_imemReq <= 1'b1;
          end
        end
        DECODE: begin
          r_state <= EXECUTE;
        end
        EXECUTE: begin
          if (dec_halt) begin
            r_halted <= 1'b1;
            r_state  <= HALTED;
          end else if (isMemOp(w_opcode)) begin
            r_dmemReq <= 1'b1;
            r_dmemWe  <= (w_opcode == OP_STORE);
            r_state   <= MEM;
          end else begin
            r_wbStrobe <= 1'b1;
            r_state    <= WB;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            r_dmemReq  <= 1'b0;
            r_dmemWe   <= 1'b0;
            r_wbStrobe <= 1'b1;
            r_state    <= WB;
          end
        end
        WB: begin
          // Saturate rather than wrap so a long run never looks like a reset.
          if (r_retired != {CNT_W{1'b1}}) begin
            r_retired <= r_retired + CNT_W'(1);
          end
          r_imemReq <= 1'b1;
          r_state   <= FETCH;
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_imemReq <= 1'b0;
          r_dmemReq <= 1'b0;
          r_dmemWe  <= 1'b0;
          r_state   <= FETCH;
        end
      endcase
    end
  end

  // The write strobe is the registered writeback-cycle marker qualified by
  // the decoder's request in that same cycle, so dec_write_en presented in
  // any other state can never reach the register file.
  assign rf_write_en   = r_wbStrobe & dec_write_en;

  assign imem_req      = r_imemReq;
  assign imem_addr     = w_pc;
  assign instruction   = r_ir;
  assign dmem_req      = r_dmemReq;
  assign dmem_we       = r_dmemWe;
  assign pc            = w_pc;
  assign halted        = r_halted;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_core_sequencer.sv
// ---------------------------------------------------------------------------
// tb_core_sequencer
// Directed bench for core_sequencer. Each table row is one instruction with
// its memory wait states, decoder responses and the PC / retired count /
// latency expected once it completes. Decoder strobes are driven to their
// "wrong" values outside writeback, and acks are held high outside their
// request states, so those inputs must be ignored there.
// ---------------------------------------------------------------------------
module tb_core_sequencer;
  import protocore_pkg::*;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instruction;
  logic               dec_write_en;
  logic               dec_halt;
  logic               dec_pc_overwrite;
  logic [7:0]         alu_result;
  logic               rf_write_en;
  logic               dmem_req;
  logic               dmem_we;
  logic               dmem_ack;
  logic [PC_W-1:0]    pc;
  logic               halted;
  logic [CNT_W-1:0]   retired_count;

  core_sequencer #(
    .PC_W     (PC_W),
    .RESET_PC (8'h00),
    .CNT_W    (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .instruction      (instruction),
    .dec_write_en     (dec_write_en),
    .dec_halt         (dec_halt),
    .dec_pc_overwrite (dec_pc_overwrite),
    .alu_result       (alu_result),
    .rf_write_en      (rf_write_en),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_ack         (dmem_ack),
    .pc               (pc),
    .halted           (halted),
    .retired_count    (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          doReset;
    logic [23:0] word;
    int          imemWait;
    int          dmemWait;
    bit          writeEn;
    bit          overwrite;
    logic [7:0]  alu;
    bit          halt;
    logic [7:0]  expPc;
    int          expRetired;
    int          expCycles;
  } vec_t;

  vec_t        vecs[$];
  int          checks   = 0;
  int          failures = 0;
  logic [23:0] modelIr;

  int obsImemReq, obsDmemReq, obsDmemWe, obsRfNoise, obsHaltEarly, obsIrBad;
  bit obsRfWb;

  // Records one comparison and reports it when it does not hold.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Inputs that the sequencer must ignore in the current state.
  task automatic driveIdle();
    imem_ack         = 1'b1;
    dmem_ack         = 1'b1;
    imem_rdata       = 24'h5A5A5A;
    dec_halt         = 1'b0;
    dec_write_en     = 1'b1;
    dec_pc_overwrite = 1'b1;
    alu_result       = 8'hC3;
  endtask

  // Accumulates per-cycle observations; inputs must already be driven.
  task automatic observeCycle(input bit isWb);
    if (imem_req) obsImemReq++;
    if (dmem_req) obsDmemReq++;
    if (dmem_req && dmem_we) obsDmemWe++;
    if (halted) obsHaltEarly++;
    #1;
    if (isWb) obsRfWb = rf_write_en;
    else if (rf_write_en) obsRfNoise++;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    driveIdle();
    nextCycle();
    nextCycle();
    checkOutput("rst_imem_req", imem_req, 0);
    checkOutput("rst_dmem_req", dmem_req, 0);
    checkOutput("rst_dmem_we", dmem_we, 0);
    checkOutput("rst_rf_write_en", rf_write_en, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_retired", retired_count, 0);
    checkOutput("rst_instruction", instruction, 0);
    rst_n = 1'b1;
    modelIr = 24'h0;
    #1 checkOutput("release_req_low", imem_req, 0);
    nextCycle();
    checkOutput("release_req_rise", imem_req, 1);
    checkOutput("release_ack_ignored", instruction, 0);
  endtask

  // Runs one instruction through the core and checks its effects.
  task automatic applyStimulus(input vec_t v);
    int  cyc;
    int  budget;
    int  bad;
    bit  isMem;
    isMem = isMemOp(v.word[23:20]);
    if (v.doReset) doReset();
    driveIdle();
    budget = 0;
    while (!imem_req && budget < 20) begin
      nextCycle();
      budget++;
    end
    if (!imem_req) begin
      checkOutput("fetch_req_timeout", 0, 1);
      return;
    end
    obsImemReq = 0; obsDmemReq = 0; obsDmemWe = 0;
    obsRfNoise = 0; obsHaltEarly = 0; obsIrBad = 0; obsRfWb = 1'b0;
    cyc = 0;

    for (int w = 0; w <= v.imemWait; w++) begin
      driveIdle();
      imem_ack   = (w == v.imemWait);
      imem_rdata = imem_ack ? v.word : 24'h5A5A5A;
      if (instruction !== modelIr) obsIrBad++;
      observeCycle(1'b0);
      nextCycle(); cyc++;
    end
    modelIr = v.word;

    driveIdle();
    checkOutput("ir_loaded", instruction, modelIr);
    observeCycle(1'b0);
    nextCycle(); cyc++;

    driveIdle();
    dec_halt = v.halt;
    observeCycle(1'b0);
    nextCycle(); cyc++;

    if (v.halt) begin
      driveIdle();
      checkOutput("halted_set", halted, 1);
      checkOutput("halt_pc", pc, 32'(v.expPc));
      checkOutput("halt_retired", retired_count, v.expRetired);
      checkOutput("halt_cycles", cyc, v.expCycles);
      checkOutput("halt_imem_req_cycles", obsImemReq, v.imemWait + 1);
      checkOutput("halt_not_early", obsHaltEarly, 0);
      checkOutput("halt_rf_noise", obsRfNoise, 0);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
        driveIdle();
        #1;
        if (imem_req || dmem_req || rf_write_en || !halted || pc !== v.expPc) bad++;
        nextCycle();
      end
      checkOutput("halted_frozen", bad, 0);
      return;
    end

    if (isMem) begin
      for (int d = 0; d <= v.dmemWait; d++) begin
        driveIdle();
        dmem_ack = (d == v.dmemWait);
        observeCycle(1'b0);
        nextCycle(); cyc++;
      end
    end

    driveIdle();
    dec_write_en     = v.writeEn;
    dec_pc_overwrite = v.overwrite;
    alu_result       = v.alu;
    observeCycle(1'b1);
    nextCycle(); cyc++;
    driveIdle();

    checkOutput("pc", pc, 32'(v.expPc));
    checkOutput("imem_addr", imem_addr, 32'(v.expPc));
    checkOutput("retired", retired_count, v.expRetired);
    checkOutput("cycles", cyc, v.expCycles);
    checkOutput("imem_req_cycles", obsImemReq, v.imemWait + 1);
    checkOutput("ir_stable_in_wait", obsIrBad, 0);
    checkOutput("dmem_req_cycles", obsDmemReq, isMem ? v.dmemWait + 1 : 0);
    checkOutput("dmem_we_cycles", obsDmemWe,
                (v.word[23:20] == OP_STORE) ? v.dmemWait + 1 : 0);
    checkOutput("rf_write_wb", obsRfWb, v.writeEn);
    checkOutput("rf_write_noise", obsRfNoise, 0);
    checkOutput("not_halted", halted, 0);
  endtask

  function automatic vec_t mkVec(bit rst, logic [23:0] word, int iw, int dw,
                                 bit we, bit ow, logic [7:0] alu, bit halt,
                                 logic [7:0] expPc, int expRet, int expCyc);
    vec_t v;
    v.doReset = rst; v.word = word; v.imemWait = iw; v.dmemWait = dw;
    v.writeEn = we; v.overwrite = ow; v.alu = alu; v.halt = halt;
    v.expPc = expPc; v.expRetired = expRet; v.expCycles = expCyc;
    return v;
  endfunction

  initial begin
    vec_t        addVec;
    logic [23:0] haltWord;
    haltWord = {OP_HALT, 20'h00000};
    rst_n = 1'b0;
    driveIdle();

    // ADD, ADD, HALT with zero-wait fetches
    vecs.push_back(mkVec(1, 24'h112345, 0, 0, 1, 0, 8'h00, 0, 8'h01, 1, 4));
    vecs.push_back(mkVec(0, 24'h1ABCDE, 0, 0, 1, 0, 8'h00, 0, 8'h02, 2, 4));
    vecs.push_back(mkVec(0, haltWord,   0, 0, 0, 0, 8'h00, 1, 8'h02, 2, 3));
    // three-cycle fetch waits
    vecs.push_back(mkVec(1, 24'h100001, 3, 0, 0, 0, 8'h00, 0, 8'h01, 1, 7));
    vecs.push_back(mkVec(0, 24'h200002, 3, 0, 1, 0, 8'h00, 0, 8'h02, 2, 7));
    vecs.push_back(mkVec(0, 24'h300003, 0, 0, 1, 0, 8'h00, 0, 8'h03, 3, 4));
    vecs.push_back(mkVec(0, 24'h400004, 0, 0, 0, 0, 8'h00, 0, 8'h04, 4, 4));
    vecs.push_back(mkVec(0, 24'h500005, 0, 0, 1, 0, 8'h00, 0, 8'h05, 5, 4));
    // jump from pc=5 to 0x20
    vecs.push_back(mkVec(0, 24'hE00020, 0, 0, 0, 1, 8'h20, 0, 8'h20, 6, 4));
    // store with two dmem wait cycles, then zero-wait load
    vecs.push_back(mkVec(0, 24'hB12345, 0, 2, 0, 0, 8'h00, 0, 8'h21, 7, 7));
    vecs.push_back(mkVec(0, 24'hA00001, 0, 0, 1, 0, 8'h00, 0, 8'h22, 8, 5));
    // jump to 0xFF then wrap to 0x00
    vecs.push_back(mkVec(0, 24'hE000FF, 0, 0, 1, 1, 8'hFF, 0, 8'hFF, 9, 4));
    vecs.push_back(mkVec(0, 24'h1000FF, 0, 0, 1, 0, 8'h00, 0, 8'h00, 10, 4));
    // undefined opcodes fall through without a write
    vecs.push_back(mkVec(0, 24'hC00000, 0, 0, 0, 0, 8'h00, 0, 8'h01, 11, 4));
    vecs.push_back(mkVec(0, 24'hD00000, 1, 0, 0, 0, 8'h00, 0, 8'h02, 12, 5));
    vecs.push_back(mkVec(0, haltWord,   0, 0, 0, 0, 8'h00, 1, 8'h02, 12, 3));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset while a fetch is outstanding and the ack arrives around reset.
    doReset();
    addVec = mkVec(0, 24'h177777, 0, 0, 1, 0, 8'h00, 0, 8'h01, 1, 4);
    applyStimulus(addVec);
    driveIdle();
    imem_ack = 1'b0;
    nextCycle();
    checkOutput("pending_req_high", imem_req, 1);
    imem_ack   = 1'b1;
    imem_rdata = 24'h777777;
    #2 rst_n = 1'b0;
    #1 checkOutput("req_drop_async", imem_req, 0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("post_rst_req", imem_req, 1);
    checkOutput("post_rst_ir", instruction, 0);
    checkOutput("post_rst_pc", pc, 0);
    checkOutput("post_rst_retired", retired_count, 0);
    checkOutput("post_rst_halted", halted, 0);
    imem_ack = 1'b0;
    nextCycle();
    checkOutput("late_ack_ignored", instruction, 0);
    modelIr = 24'h0;
    applyStimulus(mkVec(0, 24'h211111, 0, 0, 1, 0, 8'h00, 0, 8'h01, 1, 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
